// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable down-counting timer with prescaler, one-shot and periodic modes
module countdown_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] load_prescale,
  input  logic                  load_periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  expired,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  periodic_q, periodic_d;
  logic                  expired_q, expired_d;
  logic                  done_q, done_d;
  logic                  tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      pre_q      <= '0;
      pre_cnt_q  <= '0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      pre_q      <= pre_d;
      pre_cnt_q  <= pre_cnt_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
    end
  end

  assign load_ready = (state_q != RUN);
  assign running    = (state_q == RUN);
  assign count      = count_q;
  assign expired    = expired_q;
  assign done       = done_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    pre_d      = pre_q;
    pre_cnt_d  = pre_cnt_q;
    periodic_d = periodic_q;
    expired_d  = 1'b0;
    done_d     = done_q;
    tick       = (pre_cnt_q == pre_q);

    if (load_valid && load_ready) begin
      reload_d   = load_value;
      pre_d      = load_prescale;
      periodic_d = load_periodic;
      count_d    = load_value;
      pre_cnt_d  = '0;
      done_d     = 1'b0;
      state_d    = LOADED;
    end else begin
      unique case (state_q)
        LOADED: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              state_d   = DONE;
              done_d    = 1'b1;
              expired_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            count_d   = reload_q;
            pre_cnt_d = '0;
            // A zero reload value expires immediately instead of running.
            if (reload_q != '0) begin
              state_d = RUN;
              done_d  = 1'b0;
            end else begin
              done_d    = 1'b1;
              expired_d = 1'b1;
            end
          end
        end
        RUN: begin
          // Stop freezes count and prescale phase so a later start resumes seamlessly.
          if (stop) begin
            state_d = LOADED;
          end else if (tick) begin
            pre_cnt_d = '0;
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (periodic_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Programmable down-counting timer, the counterpart to the team's free-running 8-bit up-counter. Software or an upstream FSM loads a start value and prescaler through a valid/ready handshake. Start/stop controls run and pause the timer. The block counts down to zero and signals expiry with a one-cycle pulse plus a sticky done flag. It supports one-shot and periodic (auto-reload) modes and is used for timeouts and periodic event generation.

Parameters:
WIDTH, 8, width of count and load value
PRESCALE_W, 8, width of prescaler divisor field

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  load request
load_ready  output  1  block can accept a load this cycle
load_value  input  WIDTH  start/reload count
load_prescale  input  PRESCALE_W  tick divisor minus one (0 = tick every cycle)
load_periodic  input  1  1 = auto-reload on expiry, 0 = one-shot
start  input  1  begin or resume counting
stop  input  1  pause counting
count  output  WIDTH  current count value (registered)
running  output  1  high while in RUN
expired  output  1  one-cycle pulse on reaching terminal count
done  output  1  sticky one-shot completion flag

Behaviour:
- Single clock `clk`. `reset` is synchronous and active-high, sampled on the rising edge.
- Reset takes effect on the next edge, including mid-run:
  - state=IDLE, count=0, running=0, expired=0, done=0, load_ready=1
  - prescale counter=0; reload, prescale and periodic registers=0
- FSM states: IDLE, LOADED, RUN, DONE. `running` = (state==RUN).
- `load_ready` = 1 in IDLE, LOADED and DONE; 0 in RUN. `load_ready` is combinational from state.
- Load accepted on an edge where load_valid && load_ready:
  - captures reload_reg=load_value, pre_reg=load_prescale, periodic_reg=load_periodic
  - sets count=load_value, pre_cnt=0, done=0, state=LOADED
- A load in RUN (load_ready=0) is ignored; no register changes.
- `start` handling:
  - LOADED, count!=0: go to RUN.
  - LOADED, count==0: go to DONE, done=1, expired=1 for one cycle.
  - DONE: reload count=reload_reg, pre_cnt=0, go to RUN, done=0. If reload_reg==0, handle as the LOADED count==0 case.
  - IDLE: start is ignored.
- Priority in the same cycle: an accepted load beats start, so start is ignored that cycle.
- Tick generation in RUN:
  - tick when pre_cnt==pre_reg; then pre_cnt<=0, otherwise pre_cnt<=pre_cnt+1.
  - prescale 0 gives a tick every RUN cycle. Tick period = pre_reg+1 cycles.
- On a tick with count>1: count<=count-1.
- On a tick with count==1:
  - expired<=1 for exactly one cycle.
  - one-shot: count<=0, state<=DONE, done<=1.
  - periodic: count<=reload_reg, stay in RUN. Expiry period = reload_reg*(pre_reg+1) cycles.
- `stop` in RUN: go to LOADED. count and pre_cnt are held, and a later start resumes without losing prescale phase.
  - stop in the same cycle as a tick: stop wins, no decrement, no expiry.
  - stop outside RUN is ignored.
  - start and stop high together in RUN: stop wins.
- `expired` is registered and updates on the same edge as count. It is 0 in every cycle except the one following a terminal tick.
- Count arithmetic is unsigned WIDTH bits. Count never decrements below 0 and never wraps.

Test Plan:
- Reset, then load 5 (prescale 0, one-shot), then start accepted at edge E0 -> count 4,3,2,1,0 after E1..E5. expired=1 only in the cycle after E5. done=1 and running=0 from E5 onward. load_ready=0 during E0..E5.
- Load 3, prescale 2, one-shot, start -> count decrements every 3 cycles (2 at E3, 1 at E6, 0 at E9). Single expired pulse after E9.
- Load 3, prescale 0, periodic, start -> count sequence 2,1,3,2,1,3. expired pulses every 3 cycles. done stays 0.
- Load 6, prescale 1, run 3 cycles, assert stop on a tick edge -> count held, state LOADED, no decrement. Start again -> countdown resumes from the held count and phase; expiry happens exactly the number of paused cycles later.
- During RUN assert load_valid with load_value 9 -> load_ready=0, count unaffected. Load 0 then start -> done=1 and one expired pulse on the next edge, count stays 0.
- Assert reset mid-RUN with count=4 -> on the next edge count=0, running=0, done=0, expired=0, load_ready=1. A following start is ignored (IDLE).
